irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 16'h0040, byte address of handler slot 0.
REQ-002 Parameter VEC_SHIFT, default 4, log2 of handler slot size in bytes.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 int_req  input  8  raw peripheral interrupt requests; bit n is source n.
REQ-006 int_en  input  1  CPU global interrupt enable.
REQ-007 irq_ret  input  1  one-cycle pulse from CPU on iret.
REQ-008 irq_take  output  1  one-cycle pulse; CPU vectors to irq_vector.
REQ-009 irq_vector  output  16  handler address of the active source.
REQ-010 in_irq  output  1  controller is in TAKE or SERVICE.
REQ-011 sel  input  1  bus select, IO region decoded upstream.
REQ-012 we  input  1  bus write strobe, qualified by sel.
REQ-013 re  input  1  bus read strobe, qualified by sel.
REQ-014 addr  input  3  register select; addr[2:1] used, addr[0] ignored.
REQ-015 wdata  input  16  write data.
REQ-016 rdata  output  16  read data.
REQ-017 rdy  output  1  bus ready.

Function
REQ-018 int_req is registered once; a 0->1 transition of the registered bit sets pending[n].
REQ-019 Register map by addr[2:1]: 0 PEND (read pending; write-1-to-clear bits [7:0]); 1 MASK (read/write [7:0]); 2 STAT (read-only {8'h0, in_irq, 4'h0, active_id[2:0]}); 3 SWI (write-1-to-set pending bits; reads 0).
REQ-020 Unused upper bits read 0; writes to STAT are ignored.
REQ-021 Same-cycle edge-set and PEND write-clear on one bit: the set wins.
REQ-022 Eligible set = pending & MASK; priority is fixed, lowest index highest.
REQ-023 FSM states: IDLE, TAKE, SERVICE.
REQ-024 IDLE->TAKE when int_en=1 and eligible is nonzero; active_id latches the highest-priority eligible index, and that pending bit clears on the same edge.
REQ-025 TAKE lasts exactly one cycle and asserts irq_take; then TAKE->SERVICE unconditionally.
REQ-026 SERVICE->IDLE on irq_ret=1; no nesting, and new eligible sources wait.
REQ-027 irq_ret in IDLE or TAKE is ignored.
REQ-028 irq_vector = VEC_BASE + (active_id << VEC_SHIFT), mod 2^16; valid in TAKE and SERVICE, and holds its last value in IDLE.
REQ-029 After SERVICE->IDLE, the earliest next irq_take is 2 cycles after the irq_ret edge.
REQ-030 int_en=0 blocks only IDLE->TAKE; pending bits keep latching.
REQ-031 Bus read: rdata is registered on the edge where sel&re is sampled; rdy=0 in that cycle and rdy=1 in the following cycle; rdy=1 at all other times.
REQ-032 Bus write: takes effect on the sampled edge; rdy stays 1.

Reset
REQ-033 On rst: pending=0, MASK=0, FSM=IDLE, active_id=0, irq_take=0, in_irq=0, irq_vector=VEC_BASE, rdata=0, rdy=1, int_req register=0.
REQ-034 rst asserted in TAKE or SERVICE returns to IDLE with no irq_ret required; the active source is not re-pended.
REQ-035 An int_req bit held high through reset deassertion registers as an edge on the first cycle after reset.

Verification
REQ-036 MASK=8'h04, pulse int_req[2], int_en=1 -> irq_take pulses 3 cycles after the pulse edge, irq_vector=16'h0060, STAT=16'h0082.
REQ-037 MASK=8'hFF, int_req[5] and int_req[1] rise together -> source 1 taken first (vector 16'h0050); after irq_ret, source 5 is taken (vector 16'h0090) 2 cycles after the irq_ret edge.
REQ-038 int_en=0, pulse int_req[0] with MASK=1 -> no irq_take, PEND reads 16'h0001; raising int_en -> irq_take the next cycle.
REQ-039 Write SWI=16'h0080 with MASK=8'h80 in IDLE -> irq_take with vector 16'h00B0; a write of PEND=16'h0080 on the same edge as an int_req[7] rise -> bit stays set.
REQ-040 Read MASK -> rdy=0 for one cycle, then rdy=1 with rdata=16'h00xx matching MASK.
REQ-041 rst pulse during SERVICE -> in_irq=0 and irq_vector=VEC_BASE the next cycle; an irq_ret after reset has no effect.

Source files
------------

// File: rtl/irq_ctrl.sv
// 8-source vectored interrupt controller; edge to irq_take in 3 cycles, vectors to VEC_BASE + (id << VEC_SHIFT).
// Bus reads return data one cycle late with rdy low for that cycle; writes never stall.
module irq_ctrl #(
    parameter logic [15:0] VEC_BASE  = 16'h0040,
    parameter int          VEC_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  int_req,
    input  logic        int_en,
    input  logic        irq_ret,
    output logic        irq_take,
    output logic [15:0] irq_vector,
    output logic        in_irq,
    input  logic        sel,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdy
);

    typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;

    state_t      state, state_next;
    logic [7:0]  req_q, req_prev, pending, mask;
    logic [2:0]  active_id, top_id;
    logic [7:0]  rise, eligible, wr_clr, wr_set, take_clr, pending_next;
    logic        take_go, bus_wr, bus_rd;
    logic [15:0] reg_rd;
    logic        unused_bits;

    assign unused_bits = ^{addr[0], wdata[15:8]};

    assign bus_wr   = sel & we;
    assign bus_rd   = sel & re;
    assign rise     = req_q & ~req_prev;
    assign eligible = pending & mask;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        top_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) top_id = 3'(i);
        end
    end

    always_comb begin
        state_next = state;
        take_go    = 1'b0;
        case (state)
            IDLE: begin
                if (int_en && (eligible != 8'd0)) begin
                    state_next = TAKE;
                    take_go    = 1'b1;
                end
            end
            TAKE:    state_next = SERVICE;
            SERVICE: if (irq_ret) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign take_clr = take_go ? (8'd1 << top_id) : 8'd0;
    assign wr_clr   = (bus_wr && addr[2:1] == 2'd0) ? wdata[7:0] : 8'd0;
    assign wr_set   = (bus_wr && addr[2:1] == 2'd3) ? wdata[7:0] : 8'd0;

    // New edges and software sets are applied after clears so they are never lost.
    assign pending_next = (pending & ~(wr_clr | take_clr)) | rise | wr_set;

    always_comb begin
        reg_rd = 16'h0000;
        case (addr[2:1])
            2'd0:    reg_rd = {8'h00, pending};
            2'd1:    reg_rd = {8'h00, mask};
            2'd2:    reg_rd = {8'h00, in_irq, 4'h0, active_id};
            default: reg_rd = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= 8'd0;
            req_prev  <= 8'd0;
            pending   <= 8'd0;
            mask      <= 8'd0;
            active_id <= 3'd0;
            rdata     <= 16'h0000;
            rdy       <= 1'b1;
        end else begin
            state    <= state_next;
            req_q    <= int_req;
            req_prev <= req_q;
            pending  <= pending_next;
            if (take_go) active_id <= top_id;
            if (bus_wr && addr[2:1] == 2'd1) mask <= wdata[7:0];
            if (bus_rd) rdata <= reg_rd;
            rdy <= ~bus_rd;
        end
    end

    assign irq_take   = (state == TAKE);
    assign in_irq     = (state != IDLE);
    assign irq_vector = VEC_BASE + (16'(active_id) << VEC_SHIFT);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected takes are queued with their cycle and vector, a monitor pops them.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  int_req;
    logic        int_en;
    logic        irq_ret;
    logic        irq_take;
    logic [15:0] irq_vector;
    logic        in_irq;
    logic        sel;
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdy;

    typedef struct {
        int          cyc;
        logic [15:0] vec;
    } take_t;

    take_t exp_q[$];
    int    cyc   = 0;
    int    tests = 0;
    int    fails = 0;

    irq_ctrl dut (
        .clk(clk), .rst(rst), .int_req(int_req), .int_en(int_en), .irq_ret(irq_ret),
        .irq_take(irq_take), .irq_vector(irq_vector), .in_irq(in_irq),
        .sel(sel), .we(we), .re(re), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rdy(rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every irq_take pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (irq_take === 1'b1) begin
            chk("take_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                take_t e;
                e = exp_q.pop_front();
                chk("take_cycle", 32'(cyc), 32'(e.cyc));
                chk("take_vector", 32'(irq_vector), 32'(e.vec));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_take(input int dly, input logic [15:0] vec);
        take_t e;
        e.cyc = cyc + dly;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        chk("write_rdy", 32'(rdy), 32'd1);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [2:0] a, input logic [15:0] exp);
        sel = 1'b1; re = 1'b1; addr = a;
        tick();
        chk({tag, "_rdy_low"}, 32'(rdy), 32'd0);
        sel = 1'b0; re = 1'b0;
        tick();
        chk({tag, "_rdy_high"}, 32'(rdy), 32'd1);
        chk(tag, 32'(rdata), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; int_req = 8'h08; int_en = 1'b0; irq_ret = 1'b0;
        sel = 1'b0; we = 1'b0; re = 1'b0; addr = 3'd0; wdata = 16'h0000;
        tick(3);
        chk("rst_take", 32'(irq_take), 32'd0);
        chk("rst_in_irq", 32'(in_irq), 32'd0);
        chk("rst_vector", 32'(irq_vector), 32'h0040);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd1);

        // int_req[3] held through reset shows up as an edge
        rst = 1'b0;
        tick(2);
        bus_read("pend_after_rst", 3'd0, 16'h0008);
        bus_write(3'd0, 16'h0008);
        int_req = 8'h00;
        bus_read("pend_cleared", 3'd0, 16'h0000);

        // single source, MASK=04
        bus_write(3'd2, 16'h0004);
        int_en = 1'b1;
        int_req = 8'h04;
        expect_take(3, 16'h0060);
        tick();
        int_req = 8'h00;
        tick(3);
        chk("svc_in_irq", 32'(in_irq), 32'd1);
        bus_read("stat_src2", 3'd4, 16'h0082);
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
        chk("ret_idle", 32'(in_irq), 32'd0);
        chk("vector_hold", 32'(irq_vector), 32'h0060);
        tick(2);

        // simultaneous sources 5 and 1, fixed priority
        bus_write(3'd2, 16'h00FF);
        int_req = 8'h22;
        expect_take(3, 16'h0050);
        tick();
        int_req = 8'h00;
        tick(5);
        chk("no_nesting", 32'(irq_vector), 32'h0050);
        irq_ret = 1'b1;
        expect_take(2, 16'h0090);
        tick();
        irq_ret = 1'b0;
        tick();
        irq_ret = 1'b1;            // lands while in TAKE: must be ignored
        tick();
        irq_ret = 1'b0;
        chk("ret_in_take_ign", 32'(in_irq), 32'd1);
        tick();
        chk("svc_src5", 32'(in_irq), 32'd1);
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
        tick(2);

        // int_en gating: pending still latches
        int_en = 1'b0;
        bus_write(3'd2, 16'h0001);
        int_req = 8'h01;
        tick();
        int_req = 8'h00;
        tick(4);
        bus_read("pend_gated", 3'd0, 16'h0001);
        int_en = 1'b1;
        expect_take(1, 16'h0040);
        tick(3);
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
        tick(2);

        // software interrupt via SWI, addr[0] ignored
        bus_write(3'd2, 16'h0080);
        expect_take(2, 16'h00B0);
        bus_write(3'd7, 16'h0080);
        tick(3);
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
        tick(2);

        // edge set beats same-edge PEND clear
        int_en = 1'b0;
        int_req = 8'h80;
        tick();
        bus_write(3'd0, 16'h0080);
        bus_read("set_wins", 3'd0, 16'h0080);
        bus_write(3'd0, 16'h0080);
        bus_read("clear_no_edge", 3'd0, 16'h0000);
        int_req = 8'h00;
        bus_read("swi_reads0", 3'd6, 16'h0000);
        bus_read("mask_read", 3'd2, 16'h0080);

        // reset in SERVICE
        int_en = 1'b1;
        expect_take(2, 16'h00B0);
        bus_write(3'd6, 16'h0080);
        tick(2);
        chk("pre_rst_svc", 32'(in_irq), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_svc_in_irq", 32'(in_irq), 32'd0);
        chk("rst_svc_vector", 32'(irq_vector), 32'h0040);
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
        tick(3);
        chk("ret_after_rst", 32'(in_irq), 32'd0);
        bus_read("pend_not_repended", 3'd0, 16'h0000);
        bus_read("mask_rst", 3'd2, 16'h0000);

        tick(3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
